// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer.
// Condition codes are only consumed when ALU_SEQ_COND_EN is defined.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit positions inside the 4-bit {C,V,N,Z} flag word
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    // Condition codes for conditional execution
    localparam logic [1:0] COND_ALWAYS = 2'd0;
    localparam logic [1:0] COND_Z      = 2'd1;
    localparam logic [1:0] COND_C      = 2'd2;
    localparam logic [1:0] COND_N      = 2'd3;

    // True when the instruction should execute given the current flag register
    function automatic logic cond_pass(input logic [1:0] cond, input logic [3:0] flags);
        logic pass;
        case (cond)
            COND_ALWAYS: pass = 1'b1;
            COND_Z:      pass = flags[FLAG_Z];
            COND_C:      pass = flags[FLAG_C];
            default:     pass = flags[FLAG_N];
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREGS x 8-bit register file, two asynchronous read
// ports and one synchronous write port, cleared by asynchronous reset.
module alu_seq_regfile #(
    parameter int unsigned NREGS = 4,
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr_i,
    output logic [7:0]    ra_data_o,
    input  logic [AW-1:0] rb_addr_i,
    output logic [7:0]    rb_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [7:0]    wd_i
);

    logic [7:0] regs_q [NREGS];

    // Storage: cleared on reset, single write per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to an external ALU,
// writes the result back to a local register file and presents it on a
// valid/ready response port. IDLE -> EXEC -> RESP, 3 cycles minimum.
// Optional conditional execution is enabled by defining ALU_SEQ_COND_EN,
// which adds the in_cond port.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREGS = 4,
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic          in_imm_sel,
    input  logic [7:0]    in_imm,
`ifdef ALU_SEQ_COND_EN
    input  logic [1:0]    in_cond,
`endif
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_y,
    input  logic          alu_c,
    input  logic          alu_v,
    input  logic          alu_n,
    input  logic          alu_z,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data,
    output logic [3:0]    res_flags,
    output logic          res_skip
);

    state_t        state_q;
    logic          ready_q;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic [2:0]    alu_op_q;
    logic [AW-1:0] rd_q;
    logic          skip_q;
    logic [3:0]    flags_q;
    logic [7:0]    res_data_q;
    logic [3:0]    res_flags_q;
    logic          res_skip_q;
    logic          res_valid_q;

    logic          cond_ok;
    logic [AW-1:0] rf_ra_addr;
    logic [7:0]    rf_ra_data;
    logic [7:0]    rf_rb_data;
    logic          rf_we;
    logic [3:0]    alu_flags;

`ifdef ALU_SEQ_COND_EN
    assign cond_ok = cond_pass(in_cond, flags_q);
`else
    assign cond_ok = 1'b1;
`endif

    assign alu_flags = {alu_c, alu_v, alu_n, alu_z};

    // Port A follows in_ra while idle and is re-targeted to rd during EXEC,
    // so a skipped instruction can report the untouched destination value.
    assign rf_ra_addr = (state_q == ST_EXEC) ? rd_q : in_ra;
    assign rf_we      = (state_q == ST_EXEC) && !skip_q;

    alu_seq_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra_addr_i (rf_ra_addr),
        .ra_data_o (rf_ra_data),
        .rb_addr_i (in_rb),
        .rb_data_o (rf_rb_data),
        .we_i      (rf_we),
        .wa_i      (rd_q),
        .wd_i      (alu_y)
    );

    // Sequencer FSM with all externally visible outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            skip_q      <= 1'b0;
            flags_q     <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_skip_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (in_valid && ready_q) begin
                        alu_a_q  <= rf_ra_data;
                        alu_b_q  <= in_imm_sel ? in_imm : rf_rb_data;
                        alu_op_q <= in_op;
                        rd_q     <= in_rd;
                        skip_q   <= !cond_ok;
                        ready_q  <= 1'b0;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (skip_q) begin
                        res_data_q  <= rf_ra_data;
                        res_flags_q <= flags_q;
                        res_skip_q  <= 1'b1;
                    end else begin
                        res_data_q  <= alu_y;
                        flags_q     <= alu_flags;
                        res_flags_q <= alu_flags;
                        res_skip_q  <= 1'b0;
                    end
                    res_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign res_skip  = res_skip_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven bench for alu_sequencer with a small
// reference ALU stub, a response scoreboard and hand-written sequences
// for stall, reset-in-flight and (with ALU_SEQ_COND_EN) skip cases.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_ra, in_rb;
    logic       in_imm_sel;
    logic [7:0] in_imm;
`ifdef ALU_SEQ_COND_EN
    logic [1:0] in_cond;
`endif
    logic [7:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_op;
    logic       alu_c, alu_v, alu_n, alu_z;
    logic       res_valid, res_ready, res_skip;
    logic [7:0] res_data;
    logic [3:0] res_flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer #(.NREGS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
`ifdef ALU_SEQ_COND_EN
        .in_cond    (in_cond),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flags  (res_flags),
        .res_skip   (res_skip)
    );

    // ALU stub: reference behaviour, or a scripted value when script_en is set
    logic       script_en;
    logic [7:0] script_y;
    logic [3:0] script_f;

    function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] y;
        logic       c, v;
        w = '0; y = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; y = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; y = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (y[7] != a[7]); end
            3'd2: y = a & b;
            3'd3: y = ~(a ^ b);
            3'd4: y = a | b;
            3'd5: y = b;
            3'd6: begin w = {1'b0, a} + 9'd1; y = w[7:0]; c = w[8]; end
            default: y = ~a;
        endcase
        return {c, v, y[7], (y == 8'h00), y};
    endfunction

    assign {alu_c, alu_v, alu_n, alu_z, alu_y} =
        script_en ? {script_f, script_y} : alu_model(alu_op, alu_a, alu_b);

    // Scoreboard of expected responses
    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
        logic       skip;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Response monitor: handshake completes at the following rising edge
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got data 0x%0h with no pending instruction", res_data);
            end else begin
                mon_e = sb.pop_front();
                chk("res_data", {24'b0, res_data}, {24'b0, mon_e.data});
                chk("res_flags", {28'b0, res_flags}, {28'b0, mon_e.flags});
                chk("res_skip", {31'b0, res_skip}, {31'b0, mon_e.skip});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction, wait (bounded) for acceptance, check issued operands
    task automatic issue(input string nm, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic isel,
                         input logic [7:0] imm, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] ed, input logic [3:0] ef, input logic es,
                         output int acc);
        int n;
        exp_t e;
        in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
        in_imm_sel = isel; in_imm = imm; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_accept"}, {31'b0, in_ready}, 32'd1);
        e.data = ed; e.flags = ef; e.skip = es;
        sb.push_back(e);
        step();
        acc = cyc;
        chk({nm, "_alu_a"}, {24'b0, alu_a}, {24'b0, ea});
        chk({nm, "_alu_b"}, {24'b0, alu_b}, {24'b0, eb});
        chk({nm, "_alu_op"}, {29'b0, alu_op}, {29'b0, op});
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd, ra, rb;
        logic       isel;
        logic [7:0] imm;
        logic [7:0] ea, eb, ed;
        logic [3:0] ef;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int acc, prev, n;

        // op, rd, ra, rb, isel, imm, exp a, exp b, exp data, exp flags {C,V,N,Z}
        tbl[0]  = '{3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10, 8'h00, 8'h10, 8'h10, 4'b0000};
        tbl[1]  = '{3'd6, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h10, 8'h00, 8'h11, 4'b0000};
        tbl[2]  = '{3'd5, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 8'h11, 8'h11, 8'h11, 4'b0000};
        tbl[3]  = '{3'd0, 2'd0, 2'd2, 2'd3, 1'b0, 8'h00, 8'hA5, 8'h11, 8'hB6, 4'b0010};
        tbl[4]  = '{3'd1, 2'd3, 2'd3, 2'd0, 1'b1, 8'h11, 8'h11, 8'h11, 8'h00, 4'b0001};
        tbl[5]  = '{3'd0, 2'd2, 2'd2, 2'd0, 1'b1, 8'h5B, 8'hA5, 8'h5B, 8'h00, 4'b1001};
        tbl[6]  = '{3'd1, 2'd1, 2'd3, 2'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'hFF, 4'b1010};
        tbl[7]  = '{3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 8'hB6, 8'hB6, 8'h6C, 4'b1100};
        tbl[8]  = '{3'd2, 2'd0, 2'd1, 2'd0, 1'b1, 8'hF0, 8'hFF, 8'hF0, 8'hF0, 4'b0010};
        tbl[9]  = '{3'd7, 2'd2, 2'd3, 2'd0, 1'b1, 8'h00, 8'h6C, 8'h00, 8'h93, 4'b0010};
        tbl[10] = '{3'd4, 2'd1, 2'd2, 2'd0, 1'b0, 8'h00, 8'h93, 8'hF0, 8'hF3, 4'b0010};
        tbl[11] = '{3'd3, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF, 8'hF0, 8'hFF, 8'hF0, 4'b0010};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
        in_imm_sel = 1'b0; in_imm = '0; res_ready = 1'b0;
        script_en = 1'b0; script_y = '0; script_f = '0;
`ifdef ALU_SEQ_COND_EN
        in_cond = 2'd0;
`endif

        // Reset state
        #12;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_alu_a", {24'b0, alu_a}, 32'd0);
        chk("rst_alu_b", {24'b0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'b0, alu_op}, 32'd0);
        chk("rst_res_data", {24'b0, res_data}, 32'd0);
        chk("rst_res_flags", {28'b0, res_flags}, 32'd0);
        chk("rst_res_skip", {31'b0, res_skip}, 32'd0);
        step();
        rst = 1'b0;
        chk("post_rst_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        chk("post_rst_ready_high", {31'b0, in_ready}, 32'd1);

        // Scripted ALU result, response held for 5 cycles
        script_en = 1'b1; script_y = 8'hA5; script_f = 4'b1010;
        issue("first", 3'd3, 2'd2, 2'd1, 2'd0, 1'b1, 8'h5A, 8'h00, 8'h5A, 8'hA5, 4'b1010, 1'b0, acc);
        chk("first_exec_valid", {31'b0, res_valid}, 32'd0);
        step();
        script_en = 1'b0;
        chk("first_valid", {31'b0, res_valid}, 32'd1);
        chk("first_data", {24'b0, res_data}, 32'h0A5);
        chk("first_flags", {28'b0, res_flags}, 32'hA);
        in_valid = 1'b1; in_op = 3'd7; in_rd = 2'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", {24'b0, res_data}, 32'h0A5);
            chk("hold_flags", {28'b0, res_flags}, 32'hA);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        step();
        chk("hs_valid_drop", {31'b0, res_valid}, 32'd0);
        chk("hs_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_no_queued", {31'b0, res_valid}, 32'd0);
            chk("idle_alu_b_hold", {24'b0, alu_b}, 32'h05A);
            chk("idle_alu_op_hold", {29'b0, alu_op}, 32'd3);
        end

        // Table vectors, back-to-back with res_ready high
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            issue("vec", tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].isel, tbl[i].imm,
                  tbl[i].ea, tbl[i].eb, tbl[i].ed, tbl[i].ef, 1'b0, acc);
            if (i > 0) chk("throughput", acc - prev, 32'd3);
            prev = acc;
        end

        // Reset while an instruction is in EXEC: its write must not land
        issue("discard", 3'd5, 2'd3, 2'd0, 2'd0, 1'b1, 8'hEE, 8'hF0, 8'hEE, 8'hEE, 4'b0010, 1'b0, acc);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        chk("mid_rst_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_ready_back", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_no_resp", {31'b0, res_valid}, 32'd0);
        issue("after_rst_r3", 3'd6, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 4'b0000, 1'b0, acc);
        issue("after_rst_r2", 3'd0, 2'd1, 2'd2, 2'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, acc);

`ifdef ALU_SEQ_COND_EN
        // Conditional execution against the flag register
        issue("cond_setup", 3'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h33, 8'h01, 8'h33, 8'h33, 4'b0000, 1'b0, acc);
        in_cond = 2'd1;
        issue("cond_z_skip", 3'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h77, 8'h33, 8'h77, 8'h33, 4'b0000, 1'b1, acc);
        in_cond = 2'd2;
        issue("cond_c_skip", 3'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h55, 8'h33, 8'h55, 8'h33, 4'b0000, 1'b1, acc);
        in_cond = 2'd0;
        issue("cond_r0_kept", 3'd6, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 8'h33, 8'h00, 8'h34, 4'b0000, 1'b0, acc);
        issue("cond_set_z", 3'd1, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'h33, 8'h33, 8'h00, 4'b0001, 1'b0, acc);
        in_cond = 2'd1;
        issue("cond_z_exec", 3'd5, 2'd2, 2'd0, 2'd0, 1'b1, 8'h44, 8'h33, 8'h44, 8'h44, 4'b0000, 1'b0, acc);
        in_cond = 2'd0;
`endif

        // Drain outstanding responses (bounded)
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
